// File: rtl/jtframe_ddram_bram.sv
// BRAM-backed responder for the MiSTer DDRAM Avalon-MM link.
// Burst writes with byte enables, fixed-latency burst reads, optional stalls.
module jtframe_ddram_bram #(
    parameter int AW      = 10,
    parameter int LATENCY = 4,
    parameter int STALL   = 0
) (
    input  logic        rst,
    input  logic        clk,
    output logic        ddram_busy,
    input  logic [7:0]  ddram_burstcnt,
    input  logic [28:0] ddram_addr,
    input  logic        ddram_rd,
    input  logic        ddram_we,
    input  logic [63:0] ddram_din,
    input  logic [7:0]  ddram_be,
    output logic [63:0] ddram_dout,
    output logic        ddram_dout_ready,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_WAIT,
        RD_DATA
    } state_t;

    localparam int SW = (STALL > 1) ? $clog2(STALL) : 1;

    state_t          state, state_nxt;
    logic [AW-1:0]   ptr, ptr_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic [3:0]      wcnt, wcnt_nxt;
    logic [SW-1:0]   stall_cnt, stall_nxt;
    logic            stall_tc;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            rd_beat;
    logic            err_set;
    logic            busy_nxt;
    logic [7:0]      bcnt;
    logic [63:0]     mem [0:(2**AW)-1];

    assign bcnt = (ddram_burstcnt == 8'd0) ? 8'd1 : ddram_burstcnt;

    always_comb begin
        stall_nxt = '0;
        stall_tc  = 1'b0;
        if (STALL > 0) begin
            stall_nxt = (stall_cnt == SW'(STALL - 1)) ? '0 : stall_cnt + 1'b1;
            stall_tc  = (stall_nxt == SW'(STALL - 1));
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        wcnt_nxt  = wcnt;
        wr_en     = 1'b0;
        wr_addr   = ptr;
        rd_beat   = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (!ddram_busy && ddram_we) begin
                    wr_en   = 1'b1;
                    wr_addr = ddram_addr[AW-1:0];
                    err_set = ddram_rd;
                    if (bcnt > 8'd1) begin
                        state_nxt = WR;
                        ptr_nxt   = ddram_addr[AW-1:0] + 1'b1;
                        cnt_nxt   = bcnt - 8'd1;
                    end
                end else if (!ddram_busy && ddram_rd) begin
                    state_nxt = RD_WAIT;
                    ptr_nxt   = ddram_addr[AW-1:0];
                    cnt_nxt   = bcnt;
                    wcnt_nxt  = 4'(LATENCY - 1);
                end
            end
            WR: begin
                err_set = ddram_rd;
                if (!ddram_busy && ddram_we) begin
                    wr_en   = 1'b1;
                    ptr_nxt = ptr + 1'b1;
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                wcnt_nxt = wcnt - 4'd1;
                if (wcnt == 4'd1) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                // one extra cycle after the last beat keeps busy high through it
                if (cnt != 8'd0) begin
                    rd_beat = 1'b1;
                    ptr_nxt = ptr + 1'b1;
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == RD_WAIT) || (state_nxt == RD_DATA) || stall_tc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= '0;
            cnt              <= '0;
            wcnt             <= '0;
            stall_cnt        <= '0;
            ddram_busy       <= 1'b0;
            ddram_dout       <= '0;
            ddram_dout_ready <= 1'b0;
            err              <= 1'b0;
        end else begin
            state            <= state_nxt;
            ptr              <= ptr_nxt;
            cnt              <= cnt_nxt;
            wcnt             <= wcnt_nxt;
            stall_cnt        <= stall_nxt;
            ddram_busy       <= busy_nxt;
            ddram_dout_ready <= rd_beat;
            err              <= err | err_set;
            if (rd_beat) ddram_dout <= mem[ptr];
        end
    end

    // contents survive reset; gate writes so a held we cannot land during it
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int i = 0; i < 8; i++) begin
                if (ddram_be[i]) mem[wr_addr][i*8 +: 8] <= ddram_din[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_jtframe_ddram_bram.sv
// Directed bench for jtframe_ddram_bram: bursts, byte enables, wrap,
// stalls, protocol errors and asynchronous reset mid-read.
module tb_jtframe_ddram_bram;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  burstcnt;
    logic [28:0] addr;
    logic        rd, we;
    logic [63:0] din;
    logic [7:0]  be;
    logic        busy0, busy3, rdy0, rdy3, err0, err3;
    logic [63:0] dout0, dout3;
    logic        sel;
    logic        busy, rdy, err;
    logic [63:0] dout;
    int          nvec = 0;
    int          nerr = 0;
    bit          hist[$];

    assign busy = sel ? busy3 : busy0;
    assign rdy  = sel ? rdy3  : rdy0;
    assign err  = sel ? err3  : err0;
    assign dout = sel ? dout3 : dout0;

    always #5 clk = ~clk;

    jtframe_ddram_bram #(.AW(10), .LATENCY(LAT), .STALL(0)) u0 (
        .rst(rst), .clk(clk), .ddram_busy(busy0), .ddram_burstcnt(burstcnt),
        .ddram_addr(addr), .ddram_rd(rd), .ddram_we(we), .ddram_din(din),
        .ddram_be(be), .ddram_dout(dout0), .ddram_dout_ready(rdy0), .err(err0)
    );

    jtframe_ddram_bram #(.AW(10), .LATENCY(LAT), .STALL(3)) u3 (
        .rst(rst), .clk(clk), .ddram_busy(busy3), .ddram_burstcnt(burstcnt),
        .ddram_addr(addr), .ddram_rd(rd), .ddram_we(we), .ddram_din(din),
        .ddram_be(be), .ddram_dout(dout3), .ddram_dout_ready(rdy3), .err(err3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [28:0] a, input int n, input logic [63:0] d0,
                               input logic [63:0] step, input logic [7:0] b);
        int  i = 0;
        int  cyc = 0;
        logic bz;
        addr = a; burstcnt = 8'(n); be = b; din = d0; we = 1'b1;
        while (i < n && cyc < 200) begin
            bz = busy;
            hist.push_back(bz);
            @(posedge clk); #1;
            cyc++;
            if (!bz) begin
                i++;
                din = d0 + 64'(i) * step;
            end
        end
        we = 1'b0;
        check("wr_timeout", 64'(cyc < 200), 64'd1);
    endtask

    task automatic read_check(input logic [28:0] a, input int n, input int stop,
                              input logic [63:0] d0, input logic [63:0] step, input string tag);
        int w = 0;
        while (busy && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "_idle"}, 64'(busy), 64'd0);
        addr = a; burstcnt = 8'(n); rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        check({tag, "_busy_acc"}, 64'(busy), 64'd1);
        for (int c = 1; c < LAT; c++) begin
            @(posedge clk); #1;
            check({tag, "_wait_rdy"}, 64'(rdy), 64'd0);
            check({tag, "_wait_busy"}, 64'(busy), 64'd1);
        end
        for (int k = 0; k < stop; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s_rdy%0d", tag, k), 64'(rdy), 64'd1);
            check($sformatf("%s_dout%0d", tag, k), dout, d0 + 64'(k) * step);
            check($sformatf("%s_busy%0d", tag, k), 64'(busy), 64'd1);
        end
        if (stop == n) begin
            @(posedge clk); #1;
            check({tag, "_end_rdy"}, 64'(rdy), 64'd0);
            if (!sel) check({tag, "_end_busy"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int last;
        int highs;
        sel = 1'b0; rst = 1'b1; rd = 1'b0; we = 1'b0;
        addr = '0; burstcnt = '0; din = '0; be = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdy", 64'(rdy), 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        write_burst(29'h10, 4, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 8'hFF);
        read_check(29'h10, 4, 4, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, "burst");

        write_burst(29'h5, 1, 64'h0, 64'h0, 8'hFF);
        write_burst(29'h5, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h0F);
        read_check(29'h5, 1, 1, 64'h0000_0000_FFFF_FFFF, 64'h0, "be");

        write_burst(29'h3FF, 3, 64'hA0, 64'h1, 8'hFF);
        read_check(29'h3FF, 3, 3, 64'hA0, 64'h1, "wrap");
        read_check(29'h000, 1, 1, 64'hA1, 64'h0, "wrap0");
        check("err_clean", 64'(err), 64'd0);

        addr = 29'h20; burstcnt = 8'd1; din = 64'hABCD; be = 8'hFF;
        we = 1'b1; rd = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; rd = 1'b0;
        check("rdwe_err", 64'(err), 64'd1);
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk); #1;
            check("rdwe_nordy", 64'(rdy), 64'd0);
        end
        read_check(29'h20, 1, 1, 64'hABCD, 64'h0, "rdwe");

        write_burst(29'h40, 8, 64'h100, 64'h100, 8'hFF);
        read_check(29'h40, 8, 2, 64'h100, 64'h100, "abort");
        #1 rst = 1'b1;
        #1;
        check("arst_rdy", 64'(rdy), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_err", 64'(err), 64'd0);
        check("arst_dout", dout, 64'd0);
        #1 rst = 1'b0;
        read_check(29'h40, 8, 8, 64'h100, 64'h100, "after_rst");

        addr = 29'h50; burstcnt = 8'd2; din = 64'h55; be = 8'hFF; we = 1'b1;
        @(posedge clk); #1;
        rd = 1'b1; din = 64'h56;
        @(posedge clk); #1;
        we = 1'b0; rd = 1'b0;
        check("wr_rd_err", 64'(err), 64'd1);
        read_check(29'h50, 2, 2, 64'h55, 64'h1, "wr_rd");
        check("err_sticky", 64'(err), 64'd1);

        sel = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        hist.delete();
        write_burst(29'h80, 8, 64'h8000, 64'h11, 8'hFF);
        last = -1;
        highs = 0;
        foreach (hist[i]) begin
            if (hist[i]) begin
                if (last >= 0) check("stall_period", 64'(i - last), 64'd3);
                last = i;
                highs++;
            end
        end
        check("stall_seen", 64'(highs >= 2), 64'd1);
        read_check(29'h80, 8, 8, 64'h8000, 64'h11, "stall");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
